skid_pipe_reg: RTL and testbench
================================

// Module: skid_pipe_reg
// PURPOSE
//   Elastic pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
//   Upstream stage writes data in; downstream stage reads it out.
//   Full throughput (1 word/cycle), with a registered in_ready so there is no
//   combinational path from out_ready to in_ready.
//   Used between datapath stages in place of plain CE-gated registers when
//   back-pressure or flush is required.
// PARAMETERS
//   WIDTH    32   payload width in bits
//   CNT_W    16   width of the stall-cycle counter
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous reset, active-low
//   flush      in   1        synchronous discard of all held data
//   in_valid   in   1        upstream offers in_data
//   in_ready   out  1        stage can accept (registered)
//   in_data    in   WIDTH    upstream payload
//   out_valid  out  1        out_data is valid
//   out_ready  in   1        downstream accepts out_data
//   out_data   out  WIDTH    payload, driven from the main register
//   occupancy  out  2        words held: 0, 1 or 2
//   stall_cnt  out  CNT_W    cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//   Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   States: EMPTY (occ=0), ONE (main valid), TWO (main+skid valid). Encoded in occupancy.
//   Reset (rst_n=0, async):
//     state=EMPTY; main=0; skid=0; out_valid=0; in_ready=0; stall_cnt=0.
//   in_ready: register, next value = (next_state != TWO).
//     It is 0 while in reset and rises on the first clk edge after rst_n deasserts.
//   out_valid = (state != EMPTY); out_data = main.
//   Transitions (flush=0):
//     EMPTY: in_fire -> ONE, main<=in_data.
//     ONE:   in_fire & out_fire -> ONE, main<=in_data.
//            in_fire & !out_fire -> TWO, skid<=in_data.
//            !in_fire & out_fire -> EMPTY.
//            otherwise hold.
//     TWO:   in_ready=0, so no in_fire is possible.
//            out_fire -> ONE, main<=skid. Otherwise hold.
//   Ordering: words leave in arrival order; the skid word is never overtaken.
//   Latency: an in_fire in cycle N gives out_valid=1 in cycle N+1 (EMPTY case).
//   flush=1 (highest priority):
//     next state=EMPTY; in_ready<=1.
//     Any in_fire or out_fire that cycle still completes the handshake, but the
//     incoming word is dropped and main/skid contents are don't-care (not cleared).
//   stall_cnt: increments each cycle out_valid & !out_ready.
//     Saturates at all-ones. Cleared only by reset; flush does not clear it.
//   Data registers load only on the events listed above; no X propagation from
//   in_data when in_valid=0.
// TESTING
//   1. Reset release, in_valid=1 held, data 0x11:
//      in_ready=0 during reset, 1 after the 1st edge.
//      out_valid=1 with out_data=0x11 one cycle after the first in_fire.
//   2. Streaming 0x1..0x8, out_ready=1 always:
//      one word accepted and emitted per cycle, in order; occupancy stays 1.
//   3. Stream with out_ready=0 for 3 cycles:
//      occupancy goes 1->2; in_ready=0 on the next cycle; stall_cnt=3.
//      On out_ready=1, the held words emerge in order with no loss or duplication.
//   4. occupancy=2 and flush=1 together with in_valid=1:
//      next cycle occupancy=0, out_valid=0, in_ready=1; no flushed word ever appears.
//   5. out_ready=0 for 2^16+5 cycles with occupancy=1: stall_cnt saturates at 0xFFFF.
//   6. rst_n pulsed low mid-stream at occupancy=2:
//      all outputs return to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/skid_pipe_reg_if.sv
// Valid/ready stream bundle used on both sides of the skid stage.
// The master drives valid/data and the slave drives ready.
interface skid_pipe_reg_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/skid_pipe_reg.sv
// Elastic pipeline stage with a 2-entry skid buffer.
// in_ready is registered, so out_ready has no combinational path to in_ready.
module skid_pipe_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  skid_pipe_reg_if.slave   i_up,
  skid_pipe_reg_if.master  o_dn,
  output logic [1:0]       o_occupancy,
  output logic [CNT_W-1:0] o_stall_cnt
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_main;
  logic [WIDTH-1:0]   r_skid;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_load_main_in;
  logic               w_load_main_skid;
  logic               w_load_skid;

  assign w_in_fire  = i_up.valid & r_in_ready;
  assign w_out_fire = r_out_valid & o_dn.ready;

  // State register plus the flags derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state != ST_TWO);
      r_out_valid <= (w_next_state != ST_EMPTY);
    end
  end

  // Next-state logic; flush overrides every handshake outcome.
  always_comb begin
    w_next_state = r_state;
    if (i_flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) w_next_state = ST_ONE;
        ST_ONE: begin
          if (w_in_fire && !w_out_fire)      w_next_state = ST_TWO;
          else if (!w_in_fire && w_out_fire) w_next_state = ST_EMPTY;
        end
        ST_TWO:   if (w_out_fire) w_next_state = ST_ONE;
        default:  w_next_state = ST_EMPTY;
      endcase
    end
  end

  // Data-register load enables; a flushed cycle loads nothing.
  always_comb begin
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (!i_flush) begin
      case (r_state)
        ST_EMPTY: w_load_main_in = w_in_fire;
        ST_ONE: begin
          w_load_main_in = w_in_fire & w_out_fire;
          w_load_skid    = w_in_fire & ~w_out_fire;
        end
        ST_TWO:   w_load_main_skid = w_out_fire;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in)        r_main <= i_up.data;
      else if (w_load_main_skid) r_main <= r_skid;
      if (w_load_skid)           r_skid <= i_up.data;
    end
  end

  // Saturating count of back-pressured cycles; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !o_dn.ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign i_up.ready  = r_in_ready;
  assign o_dn.valid  = r_out_valid;
  assign o_dn.data   = r_main;
  assign o_occupancy = 2'(r_state);
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Directed bench for skid_pipe_reg: reset, streaming, back-pressure,
// flush, stall-counter saturation and asynchronous reset.
module tb_skid_pipe_reg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int n_vec;
  int n_err;

  skid_pipe_reg_if #(.WIDTH(WIDTH)) up_if ();
  skid_pipe_reg_if #(.WIDTH(WIDTH)) dn_if ();

  skid_pipe_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (flush),
    .i_up        (up_if),
    .o_dn        (dn_if),
    .o_occupancy (occupancy),
    .o_stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'h11;
    dn_if.ready = 1'b1;

    // Reset release with valid held high.
    step();
    step();
    chk("rst_in_ready", 32'(up_if.ready), 32'd0);
    chk("rst_out_valid", 32'(dn_if.valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", 32'(up_if.ready), 32'd1);
    chk("rel_out_valid", 32'(dn_if.valid), 32'd0);
    step();
    chk("first_valid", 32'(dn_if.valid), 32'd1);
    chk("first_data", dn_if.data, 32'h11);

    // Full-rate streaming.
    for (int i = 1; i <= 8; i++) begin
      up_if.data = 32'(i);
      step();
      chk("stream_data", dn_if.data, 32'(i));
      chk("stream_occ", 32'(occupancy), 32'd1);
      chk("stream_in_ready", 32'(up_if.ready), 32'd1);
    end
    up_if.valid = 1'b0;
    step();
    chk("drain_valid", 32'(dn_if.valid), 32'd0);
    chk("stream_stall", 32'(stall_cnt), 32'd0);

    // Back-pressure for three cycles fills the skid.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'hA1;
    step();
    chk("bp_occ1", 32'(occupancy), 32'd1);
    up_if.data = 32'hA2;
    step();
    chk("bp_occ2", 32'(occupancy), 32'd2);
    chk("bp_in_ready", 32'(up_if.ready), 32'd0);
    up_if.data = 32'hA3;
    step();
    step();
    chk("bp_stall3", 32'(stall_cnt), 32'd3);
    chk("bp_hold_occ", 32'(occupancy), 32'd2);
    chk("bp_head", dn_if.data, 32'hA1);
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    step();
    chk("bp_second", dn_if.data, 32'hA2);
    chk("bp_occ_after", 32'(occupancy), 32'd1);
    chk("bp_in_ready_back", 32'(up_if.ready), 32'd1);
    step();
    chk("bp_empty", 32'(dn_if.valid), 32'd0);
    chk("bp_stall_kept", 32'(stall_cnt), 32'd3);

    // Flush at occupancy 2 with a word offered.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'hB1;
    step();
    up_if.data = 32'hB2;
    step();
    chk("fl_occ2", 32'(occupancy), 32'd2);
    flush = 1'b1;
    up_if.data = 32'hB3;
    step();
    flush = 1'b0;
    up_if.valid = 1'b0;
    chk("fl_occ0", 32'(occupancy), 32'd0);
    chk("fl_out_valid", 32'(dn_if.valid), 32'd0);
    chk("fl_in_ready", 32'(up_if.ready), 32'd1);
    chk("fl_stall_kept", 32'(stall_cnt), 32'd5);
    dn_if.ready = 1'b1;
    step();
    chk("fl_no_ghost", 32'(dn_if.valid), 32'd0);
    up_if.valid = 1'b1;
    up_if.data  = 32'hC1;
    step();
    up_if.valid = 1'b0;
    chk("fl_next_word", dn_if.data, 32'hC1);
    chk("fl_next_occ", 32'(occupancy), 32'd1);
    step();
    chk("fl_drain", 32'(dn_if.valid), 32'd0);

    // Asynchronous reset at occupancy 2, asserted between edges.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'hD1;
    step();
    up_if.data = 32'hD2;
    step();
    chk("ar_occ2", 32'(occupancy), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_occ", 32'(occupancy), 32'd0);
    chk("ar_out_valid", 32'(dn_if.valid), 32'd0);
    chk("ar_in_ready", 32'(up_if.ready), 32'd0);
    chk("ar_data", dn_if.data, 32'h0);
    chk("ar_stall", 32'(stall_cnt), 32'd0);
    up_if.valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("ar_rel_in_ready", 32'(up_if.ready), 32'd1);

    // Stall counter saturation.
    up_if.valid = 1'b1;
    up_if.data  = 32'hE1;
    step();
    up_if.valid = 1'b0;
    chk("sat_occ", 32'(occupancy), 32'd1);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
    step();
    chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
    chk("sat_data", dn_if.data, 32'hE1);
    dn_if.ready = 1'b1;
    step();
    chk("sat_drain", 32'(dn_if.valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
